// File: rtl/ctrl_iter_pkg.sv
// Shared types for the iterative controller: state encoding and default counter width.
// Optional CORR state is enabled by defining CTRL_ITER_CORR_EN.
package ctrl_pkg;

  localparam int CW_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CORR  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ctrl_iter_if.sv
// Control/strobe bundle between the requester (master) and ctrl_iter (slave).
// Handshake: bgn is a level request accepted only in IDLE with abort low; no ready back, busy shows occupancy.
interface ctrl_iter_if import ctrl_pkg::*; #(parameter int CW = CW_DEF);

  logic          bgn;
  logic          abort;
  logic [CW-1:0] n_iter;
  logic          init;
  logic          ld;
  logic          sh;
  logic          fin;
  logic          busy;
  logic [CW-1:0] cnt;
  state_t        state;

  modport master (
    output bgn, abort, n_iter,
    input  init, ld, sh, fin, busy, cnt, state
  );

  modport slave (
    input  bgn, abort, n_iter,
    output init, ld, sh, fin, busy, cnt, state
  );

endinterface

// File: rtl/ctrl_iter_cnt.sv
// Iteration counter with terminal-count compare; a latched count of 0 runs one iteration.
module iter_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          i_clear,
  input  logic          i_inc,
  input  logic [CW-1:0] i_n_lat,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_n_eff;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_n_eff = (i_n_lat == '0) ? CW'(1) : i_n_lat;
  assign o_last  = (r_cnt == (w_n_eff - CW'(1)));
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/ctrl_iter.sv
// Iterative datapath sequencer: IDLE -> (LOAD -> SHIFT) x N [-> CORR] -> DONE.
// Define CTRL_ITER_CORR_EN to insert the one-cycle CORR step before DONE.
module ctrl_iter import ctrl_pkg::*; #(
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rst_b,
  ctrl_iter_if.slave      bus
);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_n_lat;
  logic          w_accept;
  logic          w_inc;
  logic          w_last;

  assign w_accept = (r_state == IDLE) && bus.bgn && !bus.abort;
  assign w_inc    = (r_state == SHIFT);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_n_lat <= '0;
    end else if (w_accept) begin
      r_n_lat <= bus.n_iter;
    end
  end

  iter_cnt #(.CW(CW)) u_iter_cnt (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_clear (w_accept),
    .i_inc   (w_inc),
    .i_n_lat (r_n_lat),
    .o_cnt   (bus.cnt),
    .o_last  (w_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next = LOAD;
      LOAD:  w_next = SHIFT;
`ifdef CTRL_ITER_CORR_EN
      SHIFT: w_next = w_last ? CORR : LOAD;
      CORR:  w_next = DONE;
`else
      SHIFT: w_next = w_last ? DONE : LOAD;
`endif
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Abort wins over every transition once an operation is in flight.
    if (bus.abort && (r_state != IDLE)) w_next = IDLE;
  end

  always_comb begin
    // init is Mealy on bgn; gating with rst_b keeps it low while reset is held.
    bus.init = rst_b && w_accept;
`ifdef CTRL_ITER_CORR_EN
    bus.ld   = (r_state == LOAD) || (r_state == CORR);
`else
    bus.ld   = (r_state == LOAD);
`endif
    bus.sh   = (r_state == SHIFT);
    bus.fin  = (r_state == DONE) && !bus.abort;
    bus.busy = (r_state != IDLE);
  end

  assign bus.state = r_state;

endmodule

// File: tb/tb_ctrl_iter.sv
// Directed bench for ctrl_iter: vector table plus hand sequences for long run, and mid-run reset.
module tb_ctrl_iter;
  import ctrl_pkg::*;

  localparam int CW = 4;
`ifdef CTRL_ITER_CORR_EN
  localparam int FIN_C = 32;
`else
  localparam int FIN_C = 31;
`endif

  typedef struct {
    logic          bgn;
    logic          abort;
    logic [CW-1:0] n;
    logic [CW+4:0] exp;
  } vec_t;

  logic clk;
  logic rst_b;
  int   n_vec;
  int   n_fail;
  vec_t vec_q[$];

  ctrl_iter_if #(.CW(CW)) bus ();
  ctrl_iter #(.CW(CW)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic b, input logic a, input logic [CW-1:0] n,
                     input logic i, input logic l, input logic s, input logic f,
                     input logic bz, input logic [CW-1:0] c);
    vec_t v;
    v.bgn = b; v.abort = a; v.n = n;
    v.exp = {i, l, s, f, bz, c};
    vec_q.push_back(v);
  endtask

  task automatic step(input logic b, input logic a, input logic [CW-1:0] n);
    @(negedge clk);
    bus.bgn = b; bus.abort = a; bus.n_iter = n;
    #2;
  endtask

  task automatic check(input string name, input logic [CW+4:0] exp);
    logic [CW+4:0] act;
    act = {bus.init, bus.ld, bus.sh, bus.fin, bus.busy, bus.cnt};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got init/ld/sh/fin/busy/cnt=%b want %b", name, act, exp);
    end
  endtask

  task automatic check_idle_state(input string name);
    n_vec++;
    if (bus.state !== IDLE) begin
      n_fail++;
      $display("FAIL %s: got state=%0d want IDLE", name, bus.state);
    end
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst_b = 1'b0;
    bus.bgn = 1'b0; bus.abort = 1'b0; bus.n_iter = '0;

    // Run n=4, with bgn and n_iter disturbed mid-run
    add(1,0,4, 1,0,0,0,0,0);
    add(0,0,9, 0,1,0,0,1,0);
    add(0,0,9, 0,0,1,0,1,0);
    add(1,0,0, 0,1,0,0,1,1);
    add(0,0,4, 0,0,1,0,1,1);
    add(0,0,4, 0,1,0,0,1,2);
    add(0,0,4, 0,0,1,0,1,2);
    add(0,0,4, 0,1,0,0,1,3);
    add(0,0,4, 0,0,1,0,1,3);
`ifdef CTRL_ITER_CORR_EN
    add(0,0,4, 0,1,0,0,1,4);
`endif
    add(0,0,4, 0,0,0,1,1,4);
    add(0,0,4, 0,0,0,0,0,4);
    // n=0 runs a single iteration
    add(1,0,0, 1,0,0,0,0,4);
    add(0,0,0, 0,1,0,0,1,0);
    add(0,0,0, 0,0,1,0,1,0);
`ifdef CTRL_ITER_CORR_EN
    add(0,0,0, 0,1,0,0,1,1);
`endif
    add(0,0,0, 0,0,0,1,1,1);
    add(0,0,0, 0,0,0,0,0,1);
    // abort beats bgn in IDLE, then abort in SHIFT, restart, abort in final state
    add(1,1,4, 0,0,0,0,0,1);
    add(0,0,4, 0,0,0,0,0,1);
    add(1,0,4, 1,0,0,0,0,1);
    add(0,0,4, 0,1,0,0,1,0);
    add(0,0,4, 0,0,1,0,1,0);
    add(0,0,4, 0,1,0,0,1,1);
    add(0,1,4, 0,0,1,0,1,1);
    add(0,0,4, 0,0,0,0,0,2);
    add(1,0,2, 1,0,0,0,0,2);
    add(0,0,2, 0,1,0,0,1,0);
    add(0,0,2, 0,0,1,0,1,0);
    add(0,0,2, 0,1,0,0,1,1);
    add(0,0,2, 0,0,1,0,1,1);
`ifdef CTRL_ITER_CORR_EN
    add(0,1,2, 0,1,0,0,1,2);
`else
    add(0,1,2, 0,0,0,0,1,2);
`endif
    add(0,0,2, 0,0,0,0,0,2);

    #3;
    check("reset_async", '0);
    check_idle_state("reset_state");
    repeat (2) @(negedge clk);
    bus.bgn = 1'b1;
    #1;
    check("reset_bgn_blocked", '0);
    bus.bgn = 1'b0;
    rst_b = 1'b1;

    for (int k = 0; k < vec_q.size(); k++) begin
      step(vec_q[k].bgn, vec_q[k].abort, vec_q[k].n);
      check($sformatf("table[%0d]", k), vec_q[k].exp);
    end

    // n=15 with bgn held high; n_iter wanders after acceptance
    for (int k = 0; k <= FIN_C; k++) begin
      logic          e_ld;
      logic          e_sh;
      logic [CW-1:0] e_cnt;
      step(1'b1, 1'b0, (k == 0) ? 4'd15 : 4'(k));
      e_ld  = ((k % 2 == 1) && (k <= 29)) || ((FIN_C == 32) && (k == 31));
      e_sh  = (k % 2 == 0) && (k >= 2) && (k <= 30);
      e_cnt = (k == 0) ? 4'd2 : (k <= 30) ? 4'((k - 1) / 2) : 4'd15;
      check($sformatf("n15[%0d]", k),
            {(k == 0), e_ld, e_sh, (k == FIN_C), (k > 0), e_cnt});
    end
    step(1'b0, 1'b0, 4'd0);
    check("n15_idle", {5'b00000, 4'd15});

    // Reset pulsed during SHIFT
    step(1'b1, 1'b0, 4'd4);
    check("rst_seq_init", {5'b10000, 4'd15});
    step(1'b0, 1'b0, 4'd4);
    check("rst_seq_ld", {5'b01001, 4'd0});
    step(1'b0, 1'b0, 4'd4);
    check("rst_seq_sh", {5'b00101, 4'd0});
    #1;
    rst_b = 1'b0;
    bus.bgn = 1'b1;
    #1;
    check("rst_mid_shift", '0);
    check_idle_state("rst_mid_state");
    @(negedge clk);
    bus.bgn = 1'b0;
    rst_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 4'd4);
      check($sformatf("post_rst[%0d]", k), '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_iter.md
CTRL_ITER -- requirements
Module: ctrl_iter

Interface
REQ-001 Parameter CW, default 4: width of the iteration count and counter.
REQ-002 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-003 rst_b  input  1  reset, asynchronous and active-low.
REQ-004 bgn  input  1  start request, sampled in IDLE only.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 n_iter  input  CW  requested iteration count, sampled with bgn.
REQ-007 init  output  1  datapath initialise strobe.
REQ-008 ld  output  1  datapath load/operate strobe.
REQ-009 sh  output  1  datapath shift strobe.
REQ-010 fin  output  1  operation complete, one-cycle pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 cnt  output  CW  current iteration index, registered.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, SHIFT, CORR and DONE; CORR exists only per REQ-027.
REQ-014 In IDLE with bgn=1 and abort=0, the block SHALL:
- assert init combinationally in that cycle;
- latch n_iter into an internal register n_lat;
- clear cnt;
- move to LOAD.
REQ-015 In IDLE with bgn=0, the block SHALL stay in IDLE with all strobes low.
REQ-016 LOAD SHALL assert ld for exactly one cycle and then move to SHIFT.
REQ-017 SHIFT SHALL assert sh for one cycle and increment cnt modulo 2^CW.
- If cnt equals n_lat-1, the next state SHALL be CORR (macro defined) or DONE (macro undefined).
- Otherwise the next state SHALL be LOAD.
REQ-018 A latched n_lat of 0 SHALL be treated as 1, so at least one iteration always runs.
REQ-019 DONE SHALL assert fin for exactly one cycle and then return to IDLE; bgn is not accepted in DONE.
REQ-020 bgn SHALL be ignored in every state other than IDLE, and changes to n_iter while busy SHALL have no effect.
REQ-021 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with fin=0 that cycle; the strobes of the current state still assert.
REQ-022 abort=1 in IDLE SHALL take priority over bgn: no init strobe, remain in IDLE.
REQ-023 Latency from the bgn cycle to the fin cycle SHALL be 2*N+1 cycles without CORR and 2*N+2 cycles with CORR, where N is the effective iteration count.
REQ-024 At most one of init, ld, sh and fin SHALL be high in any cycle.

Reset
REQ-025 rst_b=0 SHALL immediately and asynchronously force:
- state IDLE;
- cnt=0 and n_lat=0;
- init, ld, sh, fin and busy all 0.
REQ-026 Reset asserted mid-operation SHALL abandon the operation without a fin pulse; after release the block SHALL wait for a new bgn.

Configuration
REQ-027 Macro CTRL_ITER_CORR_EN controls the correction state:
- Defined: after the final SHIFT the FSM SHALL enter CORR for one cycle, asserting ld (correction step, busy=1), then go to DONE.
- Undefined: the final SHIFT SHALL go directly to DONE and no CORR state SHALL be synthesised.

Structure
REQ-028 The shared package ctrl_pkg SHALL hold the state enum typedef (IDLE, LOAD, SHIFT, CORR, DONE) and the default CW constant.
REQ-029 The iteration counter with its terminal-count compare SHALL be a sub-module named iter_cnt, parameterised by CW, with clear, inc, n_lat and last outputs.

Verification
REQ-030 CW=4, n_iter=4, macro off, bgn pulsed in cycle 0:
- init in cycle 0;
- ld in cycles 1, 3, 5 and 7;
- sh in cycles 2, 4, 6 and 8;
- fin in cycle 9;
- cnt ends at 4.
REQ-031 Same stimulus with CTRL_ITER_CORR_EN defined: ld in cycle 9 (CORR), fin in cycle 10.
REQ-032 n_iter=0: exactly one LOAD/SHIFT pair; fin in cycle 3 (macro off).
REQ-033 abort in cycle 4 of an n_iter=4 run: IDLE in cycle 5, no fin, busy=0; a new bgn in cycle 6 restarts cleanly with cnt=0.
REQ-034 With CW=4, n_iter=15 and bgn held high throughout:
- fin in cycle 31;
- bgn ignored while busy;
- cnt ends at 15 with no premature terminal count.
REQ-035 rst_b pulsed low in the middle of SHIFT: all outputs drop immediately; no fin after release.
